spi_slave_tx: RTL and testbench

- Transmit-side shift engine of the AXI SPI slave. Serialises 32-bit words onto sdo0..sdo3, MSB first, in single-bit or quad mode.
- A one-entry holding register decouples the word source (register/FIFO side) from the shift timing.
- Pairs with the receive shifter. Top level drives its clock with the SPI-side launch clock (inverted sclk).

---
 rtl/spi_slave_tx.sv | 116 +++++++++++
 tb/tb_spi_slave_tx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_tx.sv
// SPI slave transmit shifter: streams 32-bit words MSB first on sdo0..sdo3 in
// single-bit or quad mode, fed through a one-entry holding register.
module spi_slave_tx #(
  parameter int         DATA_WIDTH = 32,
  parameter logic [7:0] RST_TRGT   = 8'h1F
) (
  input  logic                  sclk,
  input  logic                  rstn,
  input  logic                  cs,
  input  logic                  en_quad_in,
  input  logic [7:0]            counter_in,
  input  logic                  counter_in_upd,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  done,
  output logic                  underrun,
  output logic                  sdo0,
  output logic                  sdo1,
  output logic                  sdo2,
  output logic                  sdo3,
  output logic                  sdo_oe
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e                state_q, state_d;
  logic [7:0]            counter_q, counter_d;
  logic [7:0]            trgt_q, trgt_d;
  logic [DATA_WIDTH-1:0] data_int_q, data_int_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;

  logic                  word_end;
  logic                  load;
  logic [3:0]            sdo_nib;

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      counter_q   <= 8'd0;
      trgt_q      <= RST_TRGT;
      data_int_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      trgt_q      <= trgt_d;
      data_int_q  <= data_int_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    trgt_d      = trgt_q;
    data_int_d  = data_int_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;

    word_end   = (state_q == RUN) && (counter_q == trgt_q);
    load       = !cs && (counter_in_upd || word_end);
    // A restart from counter_in_upd replaces the word boundary, so no done.
    done       = word_end && !cs && !counter_in_upd;
    underrun   = load && !hold_full_q && !data_valid;
    data_ready = !hold_full_q || load;

    if (cs) begin
      state_d     = IDLE;
      counter_d   = 8'd0;
      hold_full_d = 1'b0;
      data_int_d  = '0;
    end else if (load) begin
      state_d   = RUN;
      counter_d = 8'd0;
      if (counter_in_upd) trgt_d = counter_in;
      if (hold_full_q) begin
        data_int_d = hold_q;
        // The hold slot frees up this cycle, so a new offer refills it.
        if (data_valid) hold_d = data;
        else            hold_full_d = 1'b0;
      end else if (data_valid) begin
        data_int_d = data;
      end else begin
        data_int_d = '0;
      end
    end else begin
      if (state_q == RUN) begin
        counter_d  = counter_q + 8'd1;
        data_int_d = en_quad_in ? (data_int_q << 4) : (data_int_q << 1);
      end
      if (data_valid && !hold_full_q) begin
        hold_d      = data;
        hold_full_d = 1'b1;
      end
    end
  end

  always_comb begin
    sdo_nib = 4'b0000;
    if (state_q == RUN) begin
      if (en_quad_in) sdo_nib = data_int_q[DATA_WIDTH-1 -: 4];
      else            sdo_nib = {3'b000, data_int_q[DATA_WIDTH-1]};
    end
  end

  assign sdo0   = sdo_nib[0];
  assign sdo1   = sdo_nib[1];
  assign sdo2   = sdo_nib[2];
  assign sdo3   = sdo_nib[3];
  assign sdo_oe = (state_q == RUN);

endmodule

// File: tb/tb_spi_slave_tx.sv
// Bench for spi_slave_tx: a word-level model checked every cycle, plus
// directed single, quad, streaming, underrun, abort and async reset scenarios.
module tb_spi_slave_tx;

  logic        sclk, rstn, cs, en_quad_in, counter_in_upd, data_valid;
  logic [7:0]  counter_in;
  logic [31:0] data;
  logic        data_ready, done, underrun, sdo0, sdo1, sdo2, sdo3, sdo_oe;
  logic [3:0]  nib;

  int checks = 0;
  int errors = 0;

  spi_slave_tx dut (
    .sclk(sclk), .rstn(rstn), .cs(cs), .en_quad_in(en_quad_in),
    .counter_in(counter_in), .counter_in_upd(counter_in_upd),
    .data(data), .data_valid(data_valid), .data_ready(data_ready),
    .done(done), .underrun(underrun),
    .sdo0(sdo0), .sdo1(sdo1), .sdo2(sdo2), .sdo3(sdo3), .sdo_oe(sdo_oe)
  );

  assign nib = {sdo3, sdo2, sdo1, sdo0};

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Word-level model: the current word, its shift position and the hold queue.
  bit          m_run;
  int          m_idx;
  logic [7:0]  m_trgt;
  logic [31:0] m_word;
  logic [31:0] m_hold[$];

  function automatic bit m_end();
    return m_run && (m_idx == int'(m_trgt));
  endfunction

  function automatic bit m_load();
    return !cs && (counter_in_upd || m_end());
  endfunction

  task automatic model_reset();
    m_run  = 1'b0;
    m_idx  = 0;
    m_trgt = 8'h1F;
    m_word = '0;
    m_hold.delete();
  endtask

  task automatic model_step();
    bit ld;
    ld = m_load();
    if (cs) begin
      m_run = 1'b0;
      m_idx = 0;
      m_hold.delete();
    end else if (ld) begin
      if (counter_in_upd) m_trgt = counter_in;
      m_idx = 0;
      m_run = 1'b1;
      if (m_hold.size() > 0) begin
        m_word = m_hold.pop_front();
        if (data_valid) m_hold.push_back(data);
      end else begin
        m_word = data_valid ? data : 32'h0;
      end
    end else begin
      if (m_run) m_idx++;
      if (data_valid && m_hold.size() == 0) m_hold.push_back(data);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge sclk or negedge rstn);
      if (!rstn) model_reset();
      else       model_step();
    end
  end

  // Compare every cycle, after inputs for the cycle have been driven.
  initial begin
    logic [31:0] sh;
    logic [3:0]  exp_nib;
    bit          ld;
    forever begin
      @(negedge sclk);
      #2;
      ld = m_load();
      sh = m_word << (m_idx * (en_quad_in ? 4 : 1));
      if (!m_run)          exp_nib = 4'h0;
      else if (en_quad_in) exp_nib = sh[31:28];
      else                 exp_nib = {3'b000, sh[31]};
      chk("model_sdo", {28'h0, nib}, {28'h0, exp_nib});
      chk("model_oe", {31'h0, sdo_oe}, {31'h0, m_run});
      chk("model_done", {31'h0, done}, {31'h0, m_end() && !cs && !counter_in_upd});
      chk("model_underrun", {31'h0, underrun}, {31'h0, ld && m_hold.size() == 0 && !data_valid});
      chk("model_ready", {31'h0, data_ready}, {31'h0, (m_hold.size() == 0) || ld});
    end
  end

  task automatic drive(input logic c, input logic q, input logic [7:0] cnt,
                       input logic upd, input logic [31:0] d, input logic dv);
    cs = c; en_quad_in = q; counter_in = cnt; counter_in_upd = upd;
    data = d; data_valid = dv;
  endtask

  initial begin
    logic [31:0] pat;
    rstn = 1'b0;
    drive(0, 0, 8'd0, 0, 32'h0, 0);
    #3;
    chk("reset_ready", {31'h0, data_ready}, 32'h1);
    chk("reset_oe", {31'h0, sdo_oe}, 32'h0);
    chk("reset_sdo", {28'h0, nib}, 32'h0);
    chk("reset_done", {31'h0, done}, 32'h0);
    chk("reset_underrun", {31'h0, underrun}, 32'h0);
    @(negedge sclk);
    rstn = 1'b1;

    // Single-bit mode, 32 shift cycles.
    @(negedge sclk); drive(0, 0, 8'd0, 0, 32'hA5000001, 1);
    @(negedge sclk); drive(0, 0, 8'd31, 1, 32'h0, 0);
    #3; chk("single_idle_oe", {31'h0, sdo_oe}, 32'h0);
    pat = 32'hA5000001;
    for (int k = 0; k < 32; k++) begin
      @(negedge sclk); drive(0, 0, 8'd0, 0, 32'h0, 0);
      #3;
      chk("single_sdo0", {31'h0, sdo0}, {31'h0, pat[31-k]});
      chk("single_sdo_hi", {29'h0, sdo3, sdo2, sdo1}, 32'h0);
      chk("single_done", {31'h0, done}, {31'h0, k == 31});
    end
    @(negedge sclk); drive(1, 0, 8'd0, 0, 32'h0, 0);
    @(negedge sclk); drive(0, 0, 8'd0, 0, 32'h0, 0);

    // Quad mode, next word offered mid-word streams with no gap.
    @(negedge sclk); drive(0, 1, 8'd0, 0, 32'h12345678, 1);
    @(negedge sclk); drive(0, 1, 8'd7, 1, 32'h0, 0);
    pat = 32'h12345678;
    for (int k = 0; k < 8; k++) begin
      @(negedge sclk);
      drive(0, 1, 8'd0, 0, (k == 4) ? 32'hDEADBEEF : 32'h0, k == 4);
      #3;
      chk("quad_nib", {28'h0, nib}, {28'h0, pat[31-4*k -: 4]});
      chk("quad_done", {31'h0, done}, {31'h0, k == 7});
      if (k == 4) chk("quad_ready", {31'h0, data_ready}, 32'h1);
    end
    pat = 32'hDEADBEEF;
    for (int k = 0; k < 8; k++) begin
      @(negedge sclk); drive(0, 1, 8'd0, 0, 32'h0, 0);
      #3;
      chk("stream_nib", {28'h0, nib}, {28'h0, pat[31-4*k -: 4]});
      chk("stream_done", {31'h0, done}, {31'h0, k == 7});
      chk("stream_underrun", {31'h0, underrun}, {31'h0, k == 7});
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge sclk); drive(0, 1, 8'd0, 0, 32'h0, 0);
      #3;
      chk("underrun_nib", {28'h0, nib}, 32'h0);
      chk("underrun_oe", {31'h0, sdo_oe}, 32'h1);
    end

    // Restart with bypassed data, fill hold, then abort in cycle 5.
    @(negedge sclk); drive(0, 1, 8'd7, 1, 32'hCAFEF00D, 1);
    #3; chk("restart_done", {31'h0, done}, 32'h0);
    @(negedge sclk); drive(0, 1, 8'd0, 0, 32'h11111111, 1);
    #3; chk("abort_first_nib", {28'h0, nib}, 32'hC);
    for (int k = 1; k < 4; k++) begin
      @(negedge sclk); drive(0, 1, 8'd0, 0, 32'h0, 0);
    end
    @(negedge sclk); drive(1, 1, 8'd0, 0, 32'h0, 0);
    #3;
    chk("abort_done", {31'h0, done}, 32'h0);
    chk("abort_underrun", {31'h0, underrun}, 32'h0);
    @(negedge sclk); drive(0, 1, 8'd0, 0, 32'h0, 0);
    #3;
    chk("abort_oe", {31'h0, sdo_oe}, 32'h0);
    chk("abort_ready", {31'h0, data_ready}, 32'h1);
    chk("abort_sdo", {28'h0, nib}, 32'h0);

    // Asynchronous reset between clock edges.
    @(negedge sclk); drive(0, 1, 8'd7, 1, 32'h9ABCDEF0, 1);
    @(negedge sclk); drive(0, 1, 8'd0, 0, 32'h55555555, 1);
    #3; chk("async_pre_nib", {28'h0, nib}, 32'h9);
    @(negedge sclk); drive(0, 1, 8'd0, 0, 32'h0, 0);
    #3; chk("async_pre_nib2", {28'h0, nib}, 32'hA);
    rstn = 1'b0;
    #1;
    chk("async_oe", {31'h0, sdo_oe}, 32'h0);
    chk("async_sdo", {28'h0, nib}, 32'h0);
    chk("async_ready", {31'h0, data_ready}, 32'h1);
    chk("async_done", {31'h0, done}, 32'h0);
    @(negedge sclk); rstn = 1'b1;
    repeat (3) @(negedge sclk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
